// File: rtl/ttfs_pkg.sv
// Shared types for the TTFS spike recorder: FSM states, register offsets,
// table entry layout and the OBI request/response structs.
package ttfs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECORD,
        DONE
    } rec_state_e;

    localparam int unsigned TICK_W_MAX = 16;

    localparam logic [31:0] REG_STATUS     = 32'h00;
    localparam logic [31:0] REG_WINNER     = 32'h04;
    localparam logic [31:0] REG_CTRL       = 32'h08;
    localparam logic [31:0] REG_ENTRY_BASE = 32'h40;

    localparam int unsigned CTRL_CLEAR_BIT   = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 1;
    localparam int unsigned CTRL_IRQ_ACK_BIT = 2;

    // Ticks are held zero-extended to TICK_W_MAX so one layout serves any INPUT_RESO up to 16.
    typedef struct packed {
        logic                  valid;
        logic [TICK_W_MAX-1:0] tick;
    } entry_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_rsp_t;

endpackage

// File: rtl/ttfs_first_spike_table.sv
// Purpose: per-class first-spike tick table, spike counter and running winner.
// Latency: a recorded spike is visible in entries/count/winner one cycle later.
// Backpressure: none; a spike is recorded or dropped in the cycle it arrives.
module ttfs_first_spike_table
    import ttfs_pkg::*;
#(
    parameter int unsigned M          = 8,
    parameter int unsigned INPUT_RESO = 8,
    parameter int unsigned N_OUT      = 16,
    parameter int unsigned OUT_BASE   = 240
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        rec_en,
    input  logic                        spike,
    input  logic [M-1:0]                idx,
    input  logic [INPUT_RESO-1:0]       tick,
    input  logic [$clog2(N_OUT)-1:0]    rd_idx,
    output entry_t                      rd_entry,
    output logic [$clog2(N_OUT):0]      spike_count,
    output logic                        last_rec,
    output logic                        winner_valid,
    output logic [$clog2(N_OUT)-1:0]    winner_idx,
    output logic [TICK_W_MAX-1:0]       winner_tick
);

    localparam int unsigned KW = $clog2(N_OUT);

    entry_t                entries [N_OUT];
    logic                  in_win;
    logic [KW-1:0]         k;
    logic                  fire;
    logic [TICK_W_MAX-1:0] tick_ext;

    assign tick_ext = TICK_W_MAX'(tick);
    assign in_win   = (32'(idx) >= OUT_BASE) && (32'(idx) < OUT_BASE + N_OUT);
    assign k        = KW'(32'(idx) - OUT_BASE);
    assign fire     = rec_en && spike && in_win && !entries[k].valid;
    assign last_rec = fire && (spike_count == (KW+1)'(N_OUT - 1));
    assign rd_entry = entries[rd_idx];

    // Ticks never decrease within an inference, so only an equal-tick lower index can displace the winner.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < int'(N_OUT); i++) begin
                entries[i] <= '0;
            end
            spike_count  <= '0;
            winner_valid <= 1'b0;
            winner_idx   <= '0;
            winner_tick  <= '0;
        end else if (fire) begin
            entries[k].valid <= 1'b1;
            entries[k].tick  <= tick_ext;
            spike_count      <= spike_count + (KW+1)'(1);
            if (!winner_valid || ((tick_ext == winner_tick) && (k < winner_idx))) begin
                winner_valid <= 1'b1;
                winner_idx   <= k;
                winner_tick  <= tick_ext;
            end
        end
    end

endmodule

// File: rtl/ttfs_spike_recorder.sv
// Purpose: TTFS result recorder: FSM, first-spike table and OBI register slave.
// Latency: state/winner update one cycle after the event; OBI rvalid one cycle after gnt.
// Backpressure: none; gnt mirrors req every cycle and the spike input is never stalled.
module ttfs_spike_recorder
    import ttfs_pkg::*;
#(
    parameter int unsigned M          = 8,
    parameter int unsigned INPUT_RESO = 8,
    parameter int unsigned N_OUT      = 16,
    parameter int unsigned OUT_BASE   = 240,
    parameter type         req_t      = obi_req_t,
    parameter type         rsp_t      = obi_rsp_t
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start_i,
    input  logic                      ODIN_done_i,
    input  logic [INPUT_RESO-1:0]     tick_i,
    input  logic                      neuron_spike_i,
    input  logic [M-1:0]              neuron_idx_i,
    input  req_t                      recorder_slave_req_i,
    output rsp_t                      recorder_slave_resp_o,
    output logic                      winner_valid_o,
    output logic [$clog2(N_OUT)-1:0]  winner_idx_o,
    output logic                      rec_done_o,
    output logic                      irq_o
);

    localparam int unsigned KW = $clog2(N_OUT);

    rec_state_e            state_q, state_d;
    logic                  irq_en_q, irq_pend_q;
    logic                  rvalid_q;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           addr;
    logic                  ctrl_wr, clear_wr, ack_wr, tbl_clr, rec_en;
    logic                  last_rec;
    logic [KW:0]           spike_count;
    logic [KW-1:0]         rd_idx;
    entry_t                rd_entry;
    logic [TICK_W_MAX-1:0] winner_tick;
    logic                  unused_req;

    assign addr     = recorder_slave_req_i.addr;
    assign ctrl_wr  = recorder_slave_req_i.req && recorder_slave_req_i.we && (addr == REG_CTRL);
    assign clear_wr = ctrl_wr && recorder_slave_req_i.wdata[CTRL_CLEAR_BIT];
    assign ack_wr   = ctrl_wr && recorder_slave_req_i.wdata[CTRL_IRQ_ACK_BIT];
    assign tbl_clr  = clear_wr || start_i;
    assign rec_en   = (state_q == RECORD) && !tbl_clr;
    assign rd_idx   = KW'((addr - REG_ENTRY_BASE) >> 2);

    assign unused_req = ^{recorder_slave_req_i.be, recorder_slave_req_i.wdata[31:3], rd_entry.tick};

    ttfs_first_spike_table #(
        .M          (M),
        .INPUT_RESO (INPUT_RESO),
        .N_OUT      (N_OUT),
        .OUT_BASE   (OUT_BASE)
    ) u_table (
        .clk          (CLK),
        .rst          (RST),
        .clr          (tbl_clr),
        .rec_en       (rec_en),
        .spike        (neuron_spike_i),
        .idx          (neuron_idx_i),
        .tick         (tick_i),
        .rd_idx       (rd_idx),
        .rd_entry     (rd_entry),
        .spike_count  (spike_count),
        .last_rec     (last_rec),
        .winner_valid (winner_valid_o),
        .winner_idx   (winner_idx_o),
        .winner_tick  (winner_tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A host clear outranks start, which outranks done; a full table exits together with its last record.
    always_comb begin
        state_d = state_q;
        if (clear_wr) begin
            state_d = IDLE;
        end else if (start_i) begin
            state_d = RECORD;
        end else if ((state_q == RECORD) && (ODIN_done_i || last_rec)) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en_q <= recorder_slave_req_i.wdata[CTRL_IRQ_EN_BIT];
            end
            if (tbl_clr) begin
                irq_pend_q <= 1'b0;
            end else if ((state_q != DONE) && (state_d == DONE)) begin
                irq_pend_q <= 1'b1;
            end else if (ack_wr) begin
                irq_pend_q <= 1'b0;
            end
        end
    end

    assign rec_done_o = (state_q == DONE);
    assign irq_o      = rec_done_o && irq_pend_q && irq_en_q;

    always_comb begin
        rdata_d = '0;
        if (recorder_slave_req_i.req && !recorder_slave_req_i.we) begin
            if (addr == REG_STATUS) begin
                rdata_d[0]    = rec_done_o;
                rdata_d[1]    = winner_valid_o;
                rdata_d[2]    = irq_o;
                rdata_d[15:8] = 8'(spike_count);
            end else if (addr == REG_WINNER) begin
                rdata_d[KW-1:0] = winner_idx_o;
                rdata_d[31:16]  = winner_tick;
            end else if (addr == REG_CTRL) begin
                rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
            end else if ((addr >= REG_ENTRY_BASE) && (addr < REG_ENTRY_BASE + 4 * N_OUT)
                         && (addr[1:0] == 2'b00)) begin
                rdata_d[31]             = rd_entry.valid;
                rdata_d[INPUT_RESO-1:0] = rd_entry.tick[INPUT_RESO-1:0];
            end
        end
    end

    // rdata samples the table before this cycle's recording lands, so a racing read sees the old entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= recorder_slave_req_i.req;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        recorder_slave_resp_o        = '0;
        recorder_slave_resp_o.gnt    = recorder_slave_req_i.req;
        recorder_slave_resp_o.rvalid = rvalid_q;
        recorder_slave_resp_o.rdata  = rdata_q;
    end

endmodule
